// File: rtl/a_defines.sv
// Shared core types: architectural word, ROB tag and the common data bus record.
package a_defines;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  rob_id_t;

    // One completed result as broadcast on the common data bus.
    typedef struct packed {
        rob_id_t     rob_id;
        word_t       w_data;
        logic        r_valid;
        logic [4:0]  exc_info;
    } cdb_info_t;

endpackage

// File: rtl/mdu_result_fifo.sv
// Result buffer between the MDU issue queue and the CDB arbiter.
// Holds completed multiply/divide results until the arbiter grants a writeback
// slot; in_ready_o back-pressures the MDU pipeline when all entries are taken.
// Both handshake outputs come straight from flops, so there is no combinational
// path from out_ready_i to in_ready_o.
module mdu_result_fifo
    import a_defines::*;
#(
    parameter int DEPTH   = 4,
    parameter int PTR_LEN = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid_i,
    input  cdb_info_t          in_data_i,
    output logic               in_ready_o,
    output logic               out_valid_o,
    output cdb_info_t          out_data_o,
    input  logic               out_ready_i,
    output logic [PTR_LEN:0]   count_o
);

    // Pointer wrap relies on DEPTH filling the pointer width exactly.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PTR_LEN != $clog2(DEPTH)) begin : g_bad_depth
        $error("mdu_result_fifo: DEPTH must be a power of 2 >= 2 and PTR_LEN = clog2(DEPTH)");
    end

    localparam logic [PTR_LEN:0] CNT_ONE  = (PTR_LEN + 1)'(1);
    localparam logic [PTR_LEN:0] CNT_FULL = (PTR_LEN + 1)'(DEPTH);

    cdb_info_t          mem_q [DEPTH];
    logic [PTR_LEN-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_LEN-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_LEN:0]   count_q, count_d;
    logic               in_ready_q, in_ready_d;
    logic               push, pop;

    // Handshakes and next-state for pointers, occupancy and the ready flop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        push       = in_valid_i && in_ready_q;
        pop        = (count_q != '0) && out_ready_i;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_LEN'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_LEN'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Ready is computed from the next occupancy so the flop is correct one edge later.
        in_ready_d = (count_d < CNT_FULL);
    end

    // Control state; flush has the same effect as reset and overrides any handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n || flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Payload storage; entries are only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
        if (push && rst_n && !flush) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (count_q != '0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_FULL);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n || flush)
        push |-> in_ready_o);

    a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_o && !out_ready_i && !flush) |=> $stable(out_data_o));

endmodule

// File: tb/tb_mdu_result_fifo.sv
// Self-checking bench for mdu_result_fifo: directed vector table, a streaming
// wrap-around sequence, then randomized traffic against a queue-based model.
module tb_mdu_result_fifo;
    import a_defines::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid_i;
    cdb_info_t  in_data_i;
    logic       in_ready_o;
    logic       out_valid_o;
    cdb_info_t  out_data_o;
    logic       out_ready_i;
    logic [2:0] count_o;

    int vectors     = 0;
    int miscompares = 0;

    mdu_result_fifo #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_ready_i (out_ready_i),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       flush;
        logic       in_valid;
        logic       out_ready;
        rob_id_t    rob;
        logic       exp_ready;
        logic       exp_valid;
        logic [2:0] exp_count;
        rob_id_t    exp_rob;
    } vec_t;

    vec_t      tbl[$];
    cdb_info_t m_q[$];
    logic      m_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Deterministic payload for directed tests; rob 5 carries 32'hDEAD_BEEF.
    function automatic cdb_info_t make_info(input rob_id_t rob);
        cdb_info_t r;
        r.rob_id   = rob;
        r.w_data   = 32'hDEAD_BEEA + {26'd0, rob};
        r.r_valid  = rob[0];
        r.exc_info = rob[4:0] ^ 5'h15;
        return r;
    endfunction

    function automatic void add(input logic rs, input logic fl, input logic iv, input logic ordy,
                                input rob_id_t rob, input logic er, input logic ev,
                                input logic [2:0] ec, input rob_id_t eh);
        vec_t v;
        v.rst_n = rs; v.flush = fl; v.in_valid = iv; v.out_ready = ordy; v.rob = rob;
        v.exp_ready = er; v.exp_valid = ev; v.exp_count = ec; v.exp_rob = eh;
        tbl.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue model: one edge of the specified FIFO behaviour.
    task automatic model_edge(input logic rs, input logic fl, input logic iv,
                              input cdb_info_t d, input logic ordy);
        logic do_push, do_pop;
        do_push = iv && m_ready;
        do_pop  = (m_q.size() != 0) && ordy;
        if (!rs || fl) begin
            m_q.delete();
        end else begin
            if (do_pop)  void'(m_q.pop_front());
            if (do_push) m_q.push_back(d);
        end
        m_ready = (m_q.size() < DEPTH);
    endtask

    initial begin
        cdb_info_t sent[$];
        cdb_info_t got[$];
        rst_n = 1'b0; flush = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        in_data_i = '0;

        // rs fl iv ordy rob | ready valid count head
        add(0, 0, 0, 0,  0,   1, 0, 0,  0);   // reset
        add(0, 0, 0, 1,  0,   1, 0, 0,  0);
        add(1, 0, 0, 1,  0,   1, 0, 0,  0);   // idle, out_ready toggles
        add(1, 0, 0, 0,  0,   1, 0, 0,  0);
        add(1, 0, 1, 0,  5,   1, 1, 1,  5);   // single result held
        add(1, 0, 0, 0,  0,   1, 1, 1,  5);
        add(1, 0, 0, 0,  0,   1, 1, 1,  5);
        add(1, 0, 0, 1,  0,   1, 0, 0,  0);   // consumed
        add(1, 0, 1, 0,  1,   1, 1, 1,  1);   // fill
        add(1, 0, 1, 0,  2,   1, 1, 2,  1);
        add(1, 0, 1, 0,  3,   1, 1, 3,  1);
        add(1, 0, 1, 0,  4,   0, 1, 4,  1);
        add(1, 0, 1, 0,  7,   0, 1, 4,  1);   // 5th push refused
        add(1, 0, 0, 1,  0,   1, 1, 3,  2);   // drain in order
        add(1, 0, 0, 1,  0,   1, 1, 2,  3);
        add(1, 0, 0, 1,  0,   1, 1, 1,  4);
        add(1, 0, 0, 1,  0,   1, 0, 0,  0);
        add(1, 0, 1, 0, 20,   1, 1, 1, 20);   // push+pop at count 2
        add(1, 0, 1, 0, 21,   1, 1, 2, 20);
        add(1, 0, 1, 1, 22,   1, 1, 2, 21);
        add(1, 0, 0, 1,  0,   1, 1, 1, 22);
        add(1, 0, 0, 1,  0,   1, 0, 0,  0);
        add(1, 0, 1, 0, 30,   1, 1, 1, 30);   // flush mid-stream
        add(1, 0, 1, 0, 31,   1, 1, 2, 30);
        add(1, 0, 1, 0, 32,   1, 1, 3, 30);
        add(1, 1, 1, 0,  9,   1, 0, 0,  0);
        add(1, 0, 0, 1,  0,   1, 0, 0,  0);
        add(1, 0, 1, 1, 11,   1, 1, 1, 11);   // reset mid-operation
        add(0, 0, 1, 0, 12,   1, 0, 0,  0);
        add(1, 0, 0, 1,  0,   1, 0, 0,  0);

        foreach (tbl[i]) begin
            rst_n       = tbl[i].rst_n;
            flush       = tbl[i].flush;
            in_valid_i  = tbl[i].in_valid;
            out_ready_i = tbl[i].out_ready;
            in_data_i   = make_info(tbl[i].rob);
            step();
            check($sformatf("tbl[%0d].in_ready", i),  64'(in_ready_o),  64'(tbl[i].exp_ready));
            check($sformatf("tbl[%0d].out_valid", i), 64'(out_valid_o), 64'(tbl[i].exp_valid));
            check($sformatf("tbl[%0d].count", i),     64'(count_o),     64'(tbl[i].exp_count));
            if (tbl[i].exp_valid)
                check($sformatf("tbl[%0d].head", i), 64'(out_data_o), 64'(make_info(tbl[i].exp_rob)));
        end

        // Streaming: 10 results with both sides always ready; pointers wrap twice.
        rst_n = 1'b1; flush = 1'b0; out_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid_i = 1'b1;
            in_data_i  = make_info(rob_id_t'(40 + k));
            sent.push_back(in_data_i);
            if (out_valid_o) got.push_back(out_data_o);
            step();
            check($sformatf("stream[%0d].count_le1", k), 64'(count_o <= 3'd1), 64'd1);
        end
        in_valid_i = 1'b0;
        for (int k = 0; k < 20 && got.size() < 10; k++) begin
            if (out_valid_o) got.push_back(out_data_o);
            step();
        end
        check("stream.received", 64'(got.size()), 64'd10);
        for (int k = 0; k < 10 && k < got.size(); k++)
            check($sformatf("stream.order[%0d]", k), 64'(got[k]), 64'(sent[k]));

        // Randomized traffic against the queue model.
        rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        model_edge(rst_n, flush, in_valid_i, in_data_i, out_ready_i);
        step();
        for (int c = 0; c < 600; c++) begin
            rst_n       = ($urandom_range(0, 99) >= 2);
            flush       = ($urandom_range(0, 99) < 3);
            in_valid_i  = ($urandom_range(0, 99) < 60);
            out_ready_i = ($urandom_range(0, 99) < ((c / 100) % 2 == 0 ? 30 : 70));
            in_data_i.rob_id   = rob_id_t'($urandom);
            in_data_i.w_data   = $urandom;
            in_data_i.r_valid  = 1'($urandom);
            in_data_i.exc_info = 5'($urandom);
            model_edge(rst_n, flush, in_valid_i, in_data_i, out_ready_i);
            step();
            check($sformatf("rnd[%0d].in_ready", c),  64'(in_ready_o),  64'(m_ready));
            check($sformatf("rnd[%0d].out_valid", c), 64'(out_valid_o), 64'(m_q.size() != 0));
            check($sformatf("rnd[%0d].count", c),     64'(count_o),     64'(m_q.size()));
            if (m_q.size() != 0)
                check($sformatf("rnd[%0d].head", c), 64'(out_data_o), 64'(m_q[0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mdu_result_fifo.md
Name: mdu_result_fifo

Overview:
- Decoupling buffer directly downstream of the MDU issue queue.
- Accepts completed multiply/divide results (cdb_info_t) and holds them until the CDB arbiter grants a writeback slot.
- Drives the queue's fifo_ready input, so a stalled CDB back-pressures the MDU pipeline without losing results.
- Circular buffer; both ready and valid outputs are register-driven, so no combinational path crosses from output to input.

Parameters:
- DEPTH, 4, number of result entries; must be a power of 2, ≥2.
- PTR_LEN, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- flush  input  1  pipeline flush; synchronous; same effect as reset
- in_valid_i  input  1  MDU result valid (IQ entry_valid_o)
- in_data_i  input  cdb_info_t  MDU result payload (IQ result_o)
- in_ready_o  output  1  FIFO can accept a result this cycle (IQ fifo_ready)
- out_valid_o  output  1  head entry valid, requesting CDB
- out_data_o  output  cdb_info_t  head entry payload
- out_ready_i  input  1  CDB arbiter grant; head consumed this cycle
- count_o  output  PTR_LEN+1  occupied entries; used for debug and perf counters

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low (rst_n), sampled at posedge clk.
- Reset/flush state (`!rst_n || flush` at an edge):
  - wr_ptr_q = 0, rd_ptr_q = 0, count_q = 0
  - in_ready_o = 1, out_valid_o = 0, count_o = 0
  - Storage contents are don't-care.
- Handshakes:
  - push = in_valid_i & in_ready_o
  - pop = out_valid_o & out_ready_i
- Push: mem[wr_ptr_q] ← in_data_i; wr_ptr_q += 1 (mod DEPTH, natural wrap of PTR_LEN bits).
- Pop: rd_ptr_q += 1 (mod DEPTH).
- count_d = count_q + push − pop. Width PTR_LEN+1, so the value DEPTH is representable.
- Registered outputs:
  - in_ready_o_q ← (count_d < DEPTH)
  - out_valid_o = (count_q != 0)
  - out_data_o = mem[rd_ptr_q]
  - count_o = count_q
- Latency: a result pushed at edge t is visible on out_valid_o/out_data_o after edge t (cycle t+1). No same-cycle input-to-output bypass.
- in_ready_o does not depend combinationally on out_ready_i. A pop in cycle t reopens ready at t+1, so sustained full-throughput streaming needs DEPTH ≥ 2.
- Empty: out_valid_o=0. out_ready_i is ignored and no pop occurs. A push alone raises count to 1.
- Full (count_q==DEPTH): in_ready_o=0 and in_valid_i is ignored. A pop alone drops count to DEPTH−1; in_ready_o rises the next cycle.
- Simultaneous push and pop at 0<count<DEPTH: count unchanged, both pointers advance.
- Wrap-around: pointers wrap from DEPTH−1 to 0 transparently. Ordering is strictly FIFO.
- Flush with push/pop in the same cycle: flush wins. The pushed result is dropped and the state is empty next cycle.
- Reset or flush mid-operation: all held results are discarded. out_valid_o is 0 the cycle after.
- Payload is opaque: no field of cdb_info_t is inspected or modified (r_valid, exc_info pass through bit-exact).
- Assertions:
  - count_q ≤ DEPTH
  - no push while !in_ready_o
  - out_data_o stable while out_valid_o & !out_ready_i

Decomposition:
- cdb_info_t and the word_t/rob_id_t types stay in the shared package (a_defines); no new typedefs.
- DEPTH power-of-2 check is an elaboration-time assertion in the module.
- No sub-module: storage is a flat register array inside the block. A generic sync FIFO sub-module is not justified at this size.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 → in_ready_o=1, out_valid_o=0, count_o=0. out_ready_i toggling causes no change.
- Single result: push rob_id=5, w_data=32'hDEAD_BEEF at cycle 3, out_ready_i=0 → out_valid_o=1 from cycle 4 with the same payload, held stable; out_ready_i=1 at cycle 6 → out_valid_o=0 at cycle 7, count_o=0.
- Fill and back-pressure (DEPTH=4): push rob_id 1,2,3,4 on consecutive cycles with out_ready_i=0 → count_o=4, in_ready_o=0; a 5th in_valid_i is not accepted. Release out_ready_i → output order 1,2,3,4; in_ready_o=1 one cycle after the first pop.
- Wrap-around streaming: push 10 results with in_valid_i and out_ready_i held high → all 10 delivered in order, count_o never exceeds 1, pointers wrap twice.
- Simultaneous push/pop at count=2: count_o stays 2, and head advances to the next rob_id.
- Flush mid-stream: count_o=3, assert flush together with a push of rob_id=9 → next cycle count_o=0, out_valid_o=0, in_ready_o=1; rob_id=9 is never emitted.
